uart_tx_word_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single 32-bit UART transmit word path (system buffer
//  TX side) between NUM_REQ requesters. Grants one word at a time, drives the buffer's

---
 rtl/uart_tx_word_arbiter.sv | 89 ++++++++
 tb/tb_uart_tx_word_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word_arbiter.sv
// uart_tx_word_arbiter: round-robin sharing of the UART TX word path (req_valid/req_data/req_ack from requesters; tx_sys_data/sys_tx_data_valid/word_busy to buffer; grant_id/arb_busy/timeout_err status)
module uart_tx_word_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [DATA_W-1:0]          tx_sys_data,
  output logic                       sys_tx_data_valid,
  input  logic                       word_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic [CW-1:0] r_cnt;
  logic w_to;
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (req_valid[w_idx]) w_win = w_idx;
    end
  end
  assign w_to = r_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr_ptr <= '0;
      r_cnt <= '0;
      req_ack <= '0;
      tx_sys_data <= '0;
      sys_tx_data_valid <= 1'b0;
      grant_id <= '0;
      arb_busy <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_ack <= '0;
      sys_tx_data_valid <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        IDLE: if (!word_busy && |req_valid) begin
          tx_sys_data <= req_data[int'(w_win)*DATA_W +: DATA_W];
          grant_id <= w_win;
          req_ack <= NUM_REQ'(1) << w_win;
          sys_tx_data_valid <= 1'b1;
          arb_busy <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          r_cnt <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (word_busy) begin
          r_cnt <= '0;
          r_state <= WAIT_DONE;
        end else if (w_to) begin
          timeout_err <= 1'b1;
          arb_busy <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        WAIT_DONE: if (!word_busy) begin
          arb_busy <= 1'b0;
          r_state <= IDLE;
        end else if (w_to) begin
          timeout_err <= 1'b1;
          arb_busy <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// tb_uart_tx_word_arbiter: directed self-checking bench for uart_tx_word_arbiter
module tb_uart_tx_word_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [127:0] req_data = '0;
  logic wb = 1'b0;
  logic wb16 = 1'b0;
  logic [3:0] req_ack, t_ack;
  logic [31:0] tx_sys_data, t_data;
  logic sys_tx_data_valid, t_valid;
  logic [1:0] grant_id, t_gid;
  logic arb_busy, t_busy;
  logic timeout_err, t_to;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  uart_tx_word_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_sys_data(tx_sys_data), .sys_tx_data_valid(sys_tx_data_valid),
    .word_busy(wb), .grant_id(grant_id), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );
  uart_tx_word_arbiter #(.TIMEOUT(16)) dut16 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(t_ack), .tx_sys_data(t_data), .sys_tx_data_valid(t_valid),
    .word_busy(wb16), .grant_id(t_gid), .arb_busy(t_busy), .timeout_err(t_to)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  initial begin
    int g, bcnt, n;
    logic pend, s;
    logic [1:0] order [5];
    logic [1:0] e;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    tick();
    tick();
    rst = 1'b0;
    chk("rst_strobe", sys_tx_data_valid, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_data", tx_sys_data, 0);
    chk("rst_to", timeout_err, 0);
    req_valid = 4'b0010;
    req_data[63:32] = 32'hDEADBEEF;
    tick();
    chk("t1_strobe", sys_tx_data_valid, 1);
    chk("t1_data", tx_sys_data, 32'hDEADBEEF);
    chk("t1_ack", req_ack, 4'b0010);
    chk("t1_gid", grant_id, 1);
    chk("t1_busy", arb_busy, 1);
    req_valid = '0;
    tick();
    chk("t1_strobe_off", sys_tx_data_valid, 0);
    chk("t1_ack_off", req_ack, 0);
    chk("t1_rr_ptr", dut.r_rr_ptr, 2);
    wb = 1'b1;
    tick();
    wb = 1'b0;
    tick();
    chk("t1_idle", arb_busy, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_data = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    req_valid = 4'b1111;
    g = 0;
    bcnt = 0;
    pend = 1'b0;
    for (int c = 0; c < 600 && !(g == 5 && !arb_busy); c++) begin
      tick();
      s = sys_tx_data_valid;
      if (s) begin
        e = order[g < 5 ? g : 4];
        chk("t2_no_strobe_when_busy", wb, 0);
        chk("t2_gid", grant_id, e);
        chk("t2_ack", req_ack, 4'b0001 << e);
        chk("t2_data", tx_sys_data, 32'hA0000000 + e);
        g++;
        if (g == 5) req_valid = '0;
      end
      if (pend) begin
        wb = 1'b1;
        bcnt = 40;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) wb = 1'b0;
      end
      pend = s;
    end
    chk("t2_grants", g, 5);
    chk("t2_idle", arb_busy, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb = 1'b1;
    req_valid = 4'b0100;
    req_data[95:64] = 32'hC0FFEE00;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (sys_tx_data_valid) n++;
    end
    chk("t3_no_strobe_busy", n, 0);
    wb = 1'b0;
    tick();
    chk("t3_strobe", sys_tx_data_valid, 1);
    chk("t3_ack", req_ack, 4'b0100);
    chk("t3_gid", grant_id, 2);
    chk("t3_data", tx_sys_data, 32'hC0FFEE00);
    req_valid = '0;
    tick();
    wb = 1'b1;
    tick();
    wb = 1'b0;
    tick();
    chk("t3_idle", arb_busy, 0);
    req_valid = 4'b0010;
    req_data[63:32] = 32'h12345678;
    tick();
    chk("t5_gid", grant_id, 1);
    req_valid = '0;
    tick();
    wb = 1'b1;
    tick();
    req_valid = 4'b1000;
    req_data[127:96] = 32'h55AA55AA;
    tick();
    chk("t6_no_ack_c1", {sys_tx_data_valid, req_ack}, 0);
    tick();
    chk("t6_no_ack_c2", {sys_tx_data_valid, req_ack}, 0);
    req_valid = '0;
    tick();
    chk("t5_in_wait_done", arb_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_outputs", {req_ack, sys_tx_data_valid, grant_id, arb_busy, timeout_err}, 0);
    chk("t5_data", tx_sys_data, 0);
    chk("t5_rr_ptr", dut.r_rr_ptr, 0);
    req_valid = 4'b0001;
    req_data[31:0] = 32'h0BADF00D;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (sys_tx_data_valid) n++;
    end
    chk("t5_no_strobe_busy", n, 0);
    wb = 1'b0;
    tick();
    chk("t5_strobe", sys_tx_data_valid, 1);
    chk("t5_ack", req_ack, 4'b0001);
    chk("t5_data_after", tx_sys_data, 32'h0BADF00D);
    req_valid = '0;
    tick();
    wb = 1'b1;
    tick();
    wb = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (sys_tx_data_valid) n++;
    end
    chk("t6_never_served", n, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb = 1'b0;
    wb16 = 1'b0;
    req_valid = 4'b0001;
    tick();
    chk("t4_strobe", t_valid, 1);
    req_valid = '0;
    tick();
    n = 0;
    for (int c = 0; c < 40 && !t_to; c++) begin
      tick();
      n++;
    end
    chk("t4_timeout_cycles", n, 16);
    chk("t4_timeout_pulse", t_to, 1);
    tick();
    chk("t4_to_one_cycle", t_to, 0);
    chk("t4_idle", t_busy, 0);
    req_valid = 4'b0010;
    req_data[63:32] = 32'hFEEDFACE;
    tick();
    chk("t4_next_strobe", t_valid, 1);
    chk("t4_next_ack", t_ack, 4'b0010);
    chk("t4_next_gid", t_gid, 1);
    chk("t4_next_data", t_data, 32'hFEEDFACE);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
